// File: rtl/signed_seq_divider.sv
// -----------------------------------------------------------------------------
// signed_seq_divider
// Sequential two's-complement divider: 2N-bit dividend / N-bit divisor giving
// an N-bit quotient (truncated toward zero) and an N-bit remainder that takes
// the dividend's sign. Magnitudes are divided by a restoring algorithm, one
// bit per cycle, and the signs are applied afterwards. A quotient that does
// not fit in signed N bits saturates and raises overflow.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operand pair presented
//   in_ready     accepting operands (IDLE only, low while rst is high)
//   dividend     2N-bit two's-complement dividend
//   divisor      N-bit two's-complement divisor
//   out_valid    result registers hold a completed result
//   out_ready    consumer takes the result
//   quotient     N-bit signed quotient
//   remainder    N-bit signed remainder
//   overflow     true quotient outside signed N-bit range (quotient saturated)
//   div_by_zero  divisor was zero (quotient/remainder forced to zero)
// -----------------------------------------------------------------------------
module signed_seq_divider #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           overflow,
   output logic           div_by_zero
);

   localparam int CW = $clog2(2*N) + 1;
   localparam logic [CW-1:0]  LAST_STEP = CW'(2*N-1);
   localparam logic [2*N-1:0] Q_MAX_POS = (2*N)'((1 << (N-1)) - 1);
   localparam logic [2*N-1:0] Q_MAX_NEG = (2*N)'(1 << (N-1));
   localparam logic [N-1:0]   SAT_POS   = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]   SAT_NEG   = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;

   // r_dvd shifts the dividend magnitude out of its MSB while quotient bits
   // shift in at its LSB; after 2N steps it holds the quotient magnitude.
   logic [2*N-1:0]  r_dvd;
   logic [N:0]      r_rem;
   logic [N:0]      r_dsr;
   logic            r_sign_n;
   logic            r_sign_d;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_quot;
   logic [N-1:0]    r_remo;
   logic            r_ovf;
   logic            r_dbz;

   logic            w_accept;
   logic            w_div_zero;
   logic [2*N-1:0]  w_abs_dvd;
   logic [N:0]      w_dsr_ext;
   logic [N:0]      w_abs_dsr;
   logic [N+1:0]    w_trial;
   logic            w_ge;
   logic [N:0]      w_sub;
   logic            w_q_neg;
   logic            w_ovf;
   logic [N-1:0]    w_q_fix;
   logic [N-1:0]    w_r_fix;

   assign in_ready   = (r_state == IDLE) & ~rst;
   assign out_valid  = (r_state == DONE);
   assign w_accept   = in_valid & in_ready;
   assign w_div_zero = (divisor == {N{1'b0}});

   // |dividend| fits 2N unsigned bits even for -2^(2N-1); |divisor| needs N+1
   assign w_abs_dvd = dividend[2*N-1] ? ({(2*N){1'b0}} - dividend) : dividend;
   assign w_dsr_ext = {divisor[N-1], divisor};
   assign w_abs_dsr = divisor[N-1] ? ({(N+1){1'b0}} - w_dsr_ext) : w_dsr_ext;

   // Restoring step: the remainder stays below |divisor| <= 2^(N-1), so the
   // shifted trial value always fits in N+1 bits.
   assign w_trial = {r_rem, r_dvd[2*N-1]};
   assign w_ge    = (w_trial >= {1'b0, r_dsr});
   assign w_sub   = w_trial[N:0] - r_dsr;

   // Sign application and saturation of the quotient magnitude
   assign w_q_neg = r_sign_n ^ r_sign_d;
   assign w_ovf   = w_q_neg ? (r_dvd > Q_MAX_NEG) : (r_dvd > Q_MAX_POS);
   assign w_q_fix = w_ovf   ? (w_q_neg ? SAT_NEG : SAT_POS)
                  : (w_q_neg ? ({N{1'b0}} - r_dvd[N-1:0]) : r_dvd[N-1:0]);
   assign w_r_fix = r_sign_n ? ({N{1'b0}} - r_rem[N-1:0]) : r_rem[N-1:0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = w_div_zero ? DONE : CALC;
            end else begin
               w_next = IDLE;
            end
         end
         CALC: begin
            if (r_cnt == LAST_STEP) begin
               w_next = FIX;
            end else begin
               w_next = CALC;
            end
         end
         FIX:  w_next = DONE;
         DONE: begin
            if (out_ready) begin
               w_next = IDLE;
            end else begin
               w_next = DONE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand capture, iterative division and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dvd    <= {(2*N){1'b0}};
         r_rem    <= {(N+1){1'b0}};
         r_dsr    <= {(N+1){1'b0}};
         r_sign_n <= 1'b0;
         r_sign_d <= 1'b0;
         r_cnt    <= {CW{1'b0}};
         r_quot   <= {N{1'b0}};
         r_remo   <= {N{1'b0}};
         r_ovf    <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && w_div_zero) begin
                  r_quot <= {N{1'b0}};
                  r_remo <= {N{1'b0}};
                  r_ovf  <= 1'b0;
                  r_dbz  <= 1'b1;
               end else if (w_accept) begin
                  r_dvd    <= w_abs_dvd;
                  r_dsr    <= w_abs_dsr;
                  r_rem    <= {(N+1){1'b0}};
                  r_sign_n <= dividend[2*N-1];
                  r_sign_d <= divisor[N-1];
                  r_cnt    <= {CW{1'b0}};
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            CALC: begin
               r_rem <= w_ge ? w_sub : w_trial[N:0];
               r_dvd <= {r_dvd[2*N-2:0], w_ge};
               r_cnt <= r_cnt + CW'(1);
            end
            FIX: begin
               r_quot <= w_q_fix;
               r_remo <= w_r_fix;
               r_ovf  <= w_ovf;
               r_dbz  <= 1'b0;
            end
            DONE: begin
               r_cnt <= r_cnt;
            end
            default: begin
               r_cnt <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign quotient    = r_quot;
   assign remainder   = r_remo;
   assign overflow    = r_ovf;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_signed_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_signed_seq_divider
// Directed and random checks of signed_seq_divider (N=8) against a reference
// computed with plain signed integer division.
// -----------------------------------------------------------------------------
module tb_signed_seq_divider;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   dividend;
   logic [7:0]    divisor;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    quotient;
   logic [7:0]    remainder;
   logic          overflow;
   logic          div_by_zero;

   int errors = 0;
   int checks = 0;

   signed_seq_divider #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division, saturated to signed 8 bits
   function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic ov, output logic dz);
      longint la;
      longint lb;
      longint lq;
      longint lr;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      ov = 1'b0;
      if (lb == 0) begin
         q  = 8'h00;
         r  = 8'h00;
         dz = 1'b1;
      end else begin
         dz = 1'b0;
         lq = la / lb;
         lr = la % lb;
         if (lq > 127) begin
            ov = 1'b1;
            lq = 127;
         end else if (lq < -128) begin
            ov = 1'b1;
            lq = -128;
         end
         q = lq[7:0];
         r = lr[7:0];
      end
   endfunction

   task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                         input int hold, input bit jam);
      logic [7:0] eq;
      logic [7:0] er;
      logic       eo;
      logic       ez;
      int         lat;
      int         bound;
      ref_div(a, b, eq, er, eo, ez);
      @(negedge clk);
      bound = 0;
      while (!in_ready && bound < 50) begin
         @(negedge clk);
         bound++;
      end
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      if (jam) begin
         dividend = 16'h1234;
         divisor  = 8'h05;
      end else begin
         in_valid = 1'b0;
      end
      lat = 1;
      while (!out_valid && lat < 60) begin
         if (jam && lat == 3) chk("jam_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(lat), ez ? 32'd1 : 32'(2*N+2));
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("overflow", 32'(overflow), 32'(eo));
      chk("div_by_zero", 32'(div_by_zero), 32'(ez));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_quot", 32'(quotient), 32'(eq));
         chk("hold_rem", 32'(remainder), 32'(er));
         chk("hold_flags", 32'({overflow, div_by_zero}), 32'({eo, ez}));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("release_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("retain_quot", 32'(quotient), 32'(eq));
      chk("retain_rem", 32'(remainder), 32'(er));
   endtask

   initial begin
      int seen;
      logic [15:0] ra;
      logic [7:0]  rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 16'h0000;
      divisor   = 8'h00;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", 32'({quotient, remainder, overflow, div_by_zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      do_div(16'd100, 8'd7, 0, 1'b0);
      do_div(-16'sd100, 8'd7, 3, 1'b0);
      do_div(16'd100, -8'sd7, 0, 1'b1);
      do_div(16'd32767, -8'sd128, 0, 1'b0);
      do_div(16'h8000, 8'hFF, 0, 1'b0);
      do_div(16'd50, 8'd0, 2, 1'b0);
      do_div(16'd127, 8'd1, 0, 1'b0);
      do_div(16'd128, 8'd1, 0, 1'b0);
      do_div(-16'sd128, 8'd1, 0, 1'b0);
      do_div(-16'sd129, 8'd1, 0, 1'b0);

      // reset in the middle of a division leaves no result behind
      do_div(16'd1000, 8'd9, 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_outputs", 32'({quotient, remainder, overflow, div_by_zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ready_after", 32'(in_ready), 32'd1);
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
      do_div(16'd100, 8'd7, 0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 8'($urandom);
         if (i % 3 == 0) ra = {{8{ra[7]}}, ra[7:0]};
         do_div(ra, rb, i % 2, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
